dram_word_bridge: RTL

- Bridges a 32-bit word-access requester (CPU/LSU side) to the 128-bit, BL=8 DRAM application port.
- Writes: each word access becomes one aligned 128-bit masked write.
- Reads: each access becomes one aligned 128-bit read, and the bridge keeps a single-line read buffer.
- Sits directly upstream of the DRAM emulator/controller: it drives that block's ren/wen/addr/data/mask and consumes its data/data_valid.

---
 rtl/dram_word_bridge.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dram_word_bridge.sv
// Bridges 32-bit word requests onto the 128-bit DRAM application port, with a
// single-line read buffer that is kept coherent by write-through updates.
module dram_word_bridge #(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  input  logic                      i_req_we,
  input  logic [APP_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]               i_req_wdata,
  input  logic [3:0]                i_req_be,
  output logic                      o_req_ready,
  output logic                      o_rsp_valid,
  output logic [31:0]               o_rsp_rdata,
  output logic                      o_dram_ren,
  output logic                      o_dram_wen,
  output logic [APP_ADDR_WIDTH-2:0] o_dram_addr,
  output logic [APP_DATA_WIDTH-1:0] o_dram_data,
  output logic [APP_MASK_WIDTH-1:0] o_dram_mask,
  input  logic                      i_dram_busy,
  input  logic                      i_dram_calib,
  input  logic [APP_DATA_WIDTH-1:0] i_dram_data,
  input  logic                      i_dram_valid,
  output logic                      o_dram_busy
);

  typedef enum logic [1:0] {StIdle, StRreq, StRwait, StWreq} state_e;

  state_e                      state_q, state_d;
  logic [APP_ADDR_WIDTH-1:2]   req_addr_q, req_addr_d;
  logic [31:0]                 req_wdata_q, req_wdata_d;
  logic [3:0]                  req_be_q, req_be_d;
  logic                        req_we_q, req_we_d;
  logic [APP_DATA_WIDTH-1:0]   line_q, line_d;
  logic [APP_ADDR_WIDTH-5:0]   tag_q, tag_d;
  logic                        lvalid_q, lvalid_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
  logic [APP_MASK_WIDTH-1:0]   wmask;
  logic [6:0]                  in_off, req_off;
  logic                        accept, hit, line_match;
  logic                        unused_addr_lsb;

  // Word offset is ignored below 32-bit granularity.
  assign unused_addr_lsb = ^i_req_addr[1:0];

  assign in_off     = {i_req_addr[3:2], 5'd0};
  assign req_off    = {req_addr_q[3:2], 5'd0};
  assign o_req_ready = (state_q == StIdle) && i_dram_calib && !i_rst;
  assign accept     = i_req_valid && o_req_ready;
  assign hit        = lvalid_q && (tag_q == i_req_addr[APP_ADDR_WIDTH-1:4]);
  assign line_match = lvalid_q && (tag_q == req_addr_q[APP_ADDR_WIDTH-1:4]);

  assign o_dram_ren  = (state_q == StRreq) && !i_dram_busy && !i_rst;
  assign o_dram_wen  = (state_q == StWreq) && !i_dram_busy && !i_rst;
  assign o_dram_addr = {req_addr_q[APP_ADDR_WIDTH-1:4], 3'b000};
  assign o_dram_data = {4{req_wdata_q}};
  assign o_dram_mask = (state_q == StWreq) ? wmask : '0;
  assign o_dram_busy = 1'b0;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;

  // Mask bit 0 means the byte is written.
  always_comb begin
    wmask = '1;
    for (int k = 0; k < 4; k++) begin
      if (req_be_q[k]) wmask[{req_addr_q[3:2], 2'(k)}] = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    req_we_d    = req_we_q;
    line_d      = line_q;
    tag_d       = tag_q;
    lvalid_d    = lvalid_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          req_addr_d  = i_req_addr[APP_ADDR_WIDTH-1:2];
          req_wdata_d = i_req_wdata;
          req_be_d    = i_req_be;
          req_we_d    = i_req_we;
          if (!i_req_we) begin
            if (hit) begin
              rsp_valid_d = 1'b1;
              rsp_rdata_d = line_q[in_off +: 32];
            end else begin
              state_d = StRreq;
            end
          end else if (i_req_be == 4'b0000) begin
            rsp_valid_d = 1'b1;
          end else begin
            state_d = StWreq;
          end
        end
      end
      StRreq: begin
        if (o_dram_ren) state_d = StRwait;
      end
      StRwait: begin
        if (i_dram_valid) begin
          line_d      = i_dram_data;
          tag_d       = req_addr_q[APP_ADDR_WIDTH-1:4];
          lvalid_d    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = i_dram_data[req_off +: 32];
          state_d     = StIdle;
        end
      end
      StWreq: begin
        if (o_dram_wen) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          // Write-through keeps the buffered line from serving stale hits.
          if (line_match) begin
            for (int b = 0; b < APP_MASK_WIDTH; b++) begin
              if (!wmask[b]) line_d[b*8 +: 8] = o_dram_data[b*8 +: 8];
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_we_q    <= 1'b0;
      line_q      <= '0;
      tag_q       <= '0;
      lvalid_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      req_we_q    <= req_we_d;
      line_q      <= line_d;
      tag_q       <= tag_d;
      lvalid_q    <= lvalid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
